// File: rtl/packet_builder.sv
// Serialises one message per handshake into a 32-bit word stream:
// an 8-byte little-endian header (length, stream, per-stream sequence) followed by the payload.
module packet_builder #(
  parameter int unsigned STREAM_BITS = 3,
  parameter int unsigned MAX_PAYLOAD = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [8*MAX_PAYLOAD-1:0] msg_data,
  input  logic [5:0]               msg_len,
  input  logic [STREAM_BITS-1:0]   msg_stream,
  input  logic                     msg_val,
  output logic                     msg_ready,
  output logic [31:0]              dataOut,
  output logic                     dataOut_val,
  input  logic                     dataOut_ready,
  output logic                     dataOut_last,
  output logic [3:0]               dataOut_keep
);

  localparam int unsigned NumStreams = 2 ** STREAM_BITS;
  localparam int unsigned DataW      = 8 * MAX_PAYLOAD;

  typedef enum logic [1:0] {StIdle, StHdr0, StHdr1, StPay} state_e;

  state_e                 stateQ, stateD;
  logic [5:0]             lenQ;
  logic [STREAM_BITS-1:0] streamQ;
  logic [31:0]            seqQ;
  logic [DataW-1:0]       dataQ;
  logic [5:0]             wordIdxQ;
  logic [31:0]            seqCntQ [NumStreams];

  logic [5:0]       satLen;
  logic [DataW-1:0] maskedData;
  logic [6:0]       payWords;
  logic             payLast;
  logic [15:0]      pktLen;
  logic [15:0]      streamWide;
  logic [3:0]       tailKeep;
  logic             accept;

  assign satLen     = (msg_len > 6'(MAX_PAYLOAD)) ? 6'(MAX_PAYLOAD) : msg_len;
  assign payWords   = (7'(lenQ) + 7'd3) >> 2;
  assign payLast    = ((7'(wordIdxQ) + 7'd1) == payWords);
  assign pktLen     = 16'(lenQ) + 16'd8;
  assign streamWide = 16'(streamQ);
  assign accept     = (stateQ == StIdle) && msg_val;

  // Bytes beyond the message length are zeroed on capture so a partial last word pads with 0x00.
  always_comb begin
    maskedData = '0;
    for (int j = 0; j < MAX_PAYLOAD; j++) begin
      if (j < int'(satLen)) begin
        maskedData[DataW-1-8*j -: 8] = msg_data[DataW-1-8*j -: 8];
      end
    end
  end

  always_comb begin
    tailKeep = 4'b1111;
    unique case (lenQ[1:0])
      2'd0: tailKeep = 4'b1111;
      2'd1: tailKeep = 4'b1000;
      2'd2: tailKeep = 4'b1100;
      2'd3: tailKeep = 4'b1110;
    endcase
  end

  always_comb begin
    stateD       = stateQ;
    msg_ready    = 1'b0;
    dataOut      = '0;
    dataOut_val  = 1'b0;
    dataOut_last = 1'b0;
    dataOut_keep = '0;
    unique case (stateQ)
      StIdle: begin
        msg_ready = 1'b1;
        if (msg_val) stateD = StHdr0;
      end
      StHdr0: begin
        dataOut_val  = 1'b1;
        dataOut_keep = 4'b1111;
        dataOut      = {pktLen[7:0], pktLen[15:8], streamWide[7:0], streamWide[15:8]};
        if (dataOut_ready) stateD = StHdr1;
      end
      StHdr1: begin
        dataOut_val  = 1'b1;
        dataOut_keep = 4'b1111;
        dataOut      = {seqQ[7:0], seqQ[15:8], seqQ[23:16], seqQ[31:24]};
        dataOut_last = (lenQ == 6'd0);
        if (dataOut_ready) stateD = (lenQ == 6'd0) ? StIdle : StPay;
      end
      StPay: begin
        dataOut_val  = 1'b1;
        dataOut      = dataQ[DataW-1 -: 32];
        dataOut_last = payLast;
        dataOut_keep = payLast ? tailKeep : 4'b1111;
        if (dataOut_ready && payLast) stateD = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stateQ   <= StIdle;
      lenQ     <= '0;
      streamQ  <= '0;
      seqQ     <= '0;
      dataQ    <= '0;
      wordIdxQ <= '0;
      for (int s = 0; s < NumStreams; s++) seqCntQ[s] <= 32'd1;
    end else begin
      stateQ <= stateD;
      if (accept) begin
        lenQ                <= satLen;
        streamQ             <= msg_stream;
        seqQ                <= seqCntQ[msg_stream];
        seqCntQ[msg_stream] <= seqCntQ[msg_stream] + 32'd1;
        dataQ               <= maskedData;
        wordIdxQ            <= '0;
      end
      // The current payload word is always the top 32 bits; shift it out on each handshake.
      if ((stateQ == StPay) && dataOut_ready) begin
        dataQ    <= dataQ << 32;
        wordIdxQ <= wordIdxQ + 6'd1;
      end
    end
  end

endmodule

// File: doc/packet_builder.md
# packet_builder

Transmit-side counterpart of the sequence parser: accepts one message per handshake (stream id plus up to MAX_PAYLOAD payload bytes) and serialises it onto the 32-bit valid/ready/last word stream the parser consumes. Each packet carries an 8-byte little-endian header: total length, stream id, and a per-stream sequence number maintained here. The block sits in front of the parser in loopback benches and drives the link on the transmit path.

## Interface
- STREAM_BITS, 3: width of stream index; 2**STREAM_BITS independent sequence counters.
- MAX_PAYLOAD, 32: maximum payload bytes per message.
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- msg_data  in  8*MAX_PAYLOAD  payload; byte j at msg_data[8*MAX_PAYLOAD-1-8j -: 8].
- msg_len  in  6  payload byte count, 0..MAX_PAYLOAD (larger values saturate to MAX_PAYLOAD).
- msg_stream  in  STREAM_BITS  stream index; zero-extended to 16 bits in header.
- msg_val  in  1  message valid.
- msg_ready  out  1  message accepted when msg_val && msg_ready.
- dataOut  out  32  packet word; packet byte k of the word at bits [31-8k -: 8].
- dataOut_val  out  1  word valid.
- dataOut_ready  in  1  downstream accepts word when dataOut_val && dataOut_ready.
- dataOut_last  out  1  final word of packet.
- dataOut_keep  out  4  byte-valid mask, bit 3 = byte 0 of word; 4'b1111 except on a partial last word.

## Operation
- Packet bytes: 0-1 length (LE), 2-3 stream (LE), 4-7 seq (LE), 8.. payload in order. length = 8 + L, L = saturated msg_len.
- Word count = 2 + ceil(L/4). Unused bytes of a partial last word are 0x00; keep = 1111, 1000, 1100, 1110 for L mod 4 = 0, 1, 2, 3.
- Sequence counters: one 32-bit counter per stream, reset value 1. Accepted message takes current value, counter of that stream increments by 1 (wraps 0xFFFFFFFF -> 0). Other streams unaffected.
- FSM states: IDLE, HDR0, HDR1, PAY.
  - IDLE: msg_ready=1, dataOut_val=0. On msg_val: latch data/L/stream/seq, bump counter, -> HDR0.
  - HDR0: drive word0 {len[7:0], len[15:8], 8'h00 | stream, 8'h00}; on ready -> HDR1.
  - HDR1: drive seq LE; last=1 if L=0. On ready -> IDLE if L=0 else PAY with payload word index 0.
  - PAY: drive payload word i; last=1 on word ceil(L/4)-1. On ready: increment i, or -> IDLE after last.
- msg_ready is 0 in all states except IDLE; msg inputs ignored outside IDLE.
- Latched message registers are the sole source of dataOut; inputs may change after acceptance.

## Timing
- Reset values: msg_ready=1 (first cycle after reset deassertion), dataOut=0, dataOut_val=0, dataOut_last=0, dataOut_keep=0, all counters 1, FSM IDLE.
- Accept in cycle N -> word0 valid at N+1. No combinational path from dataOut_ready to any output.
- With dataOut_ready held high a packet occupies exactly word-count cycles; one IDLE cycle between packets (msg_ready re-asserts the cycle after the last-word handshake).
- While dataOut_val && !dataOut_ready: dataOut, last, keep held stable; val never drops without a handshake.
- Reset asserted mid-packet: next cycle all outputs at reset values, packet abandoned (no last emitted), counters back to 1.
- msg_len > MAX_PAYLOAD: treated as MAX_PAYLOAD in both length field and word count.

## Test plan
- Stream 4, L=12, payload 0x00..0x0B, ready high -> words 0x14000400, 0x01000000, 0x00010203, 0x04050607, 0x08090A0B (last, keep 1111); 5 consecutive cycles starting accept+1.
- Second stream-4 message L=13 (0x00..0x0C) then stream 5 L=4 -> 0x15000400, 0x02000000, ..., 0x0C000000 (last, keep 1000); then 0x0C000500, 0x01000000, 0x00010203 (last): per-stream seqs independent.
- L=0 on stream 0 -> two words 0x08000000, 0x01000000, last on second, keep 1111.
- Random dataOut_ready toggling (~50%) on L=32 packet -> 10 words, identical content to no-backpressure run, outputs stable while stalled, msg_ready low throughout.
- msg_len=40 -> length byte 0x28, 10 words, identical to L=32.
- Reset pulse during word 3 of a packet -> dataOut_val=0 next cycle; following stream-4 message carries seq 1.
